// File: rtl/uart_rx.sv
// 8N1 UART receiver with 16x oversampling and 2-of-3 majority voting per bit.
// Latency: valid/frame_err about 9.56 bit times after the rx falling edge, plus 2 clk of synchronizer delay.
// Backpressure: none; each byte is presented as a one-cycle valid strobe and must be captured on that cycle.
//
// Ports:
//   clk       system clock, rising edge
//   rst       asynchronous reset, active-low
//   rx        serial line, idle high, asynchronous to clk
//   data_out  last correctly framed byte
//   valid     one-cycle pulse when data_out has been updated
//   frame_err one-cycle pulse when the stop bit was sampled low
//   busy      high while a frame is in progress
module uart_rx #(
  parameter int CLK_FREQ = 50_000_000,
  parameter int BAUD     = 9600,
  parameter int OS_DIV   = CLK_FREQ / (BAUD * 16)
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic [7:0] data_out,
  output logic       valid,
  output logic       frame_err,
  output logic       busy
);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  localparam int              DIV_W   = (OS_DIV > 1) ? $clog2(OS_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_MAX = DIV_W'(OS_DIV - 1);

  state_t           state, state_nxt;
  logic             rx_m, rx_s, rx_prev;
  logic [DIV_W-1:0] div;
  logic [3:0]       tick_cnt;
  logic [2:0]       bit_cnt;
  logic [7:0]       shift;
  logic             s7, s8;

  logic os_tick, samp, decide, end_bit, maj;
  logic good_stb, err_stb;

  // Samples are taken on the first clk of oversample slots 7, 8 and 9, which
  // places them at 7/16, 8/16 and 9/16 of the bit -- centred on mid-bit.
  assign os_tick = (state != IDLE) && (div == DIV_MAX);
  assign samp    = (state != IDLE) && (div == '0);
  assign decide  = samp && (tick_cnt == 4'd9);
  assign end_bit = os_tick && (tick_cnt == 4'd15);
  assign maj     = (s7 & s8) | (s7 & rx_s) | (s8 & rx_s);
  assign busy    = (state != IDLE);

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  // Next-state and decision strobes
  always_comb begin
    state_nxt = state;
    good_stb  = 1'b0;
    err_stb   = 1'b0;
    unique case (state)
      IDLE: begin
        // Edge-triggered arm: a line stuck low never restarts a frame.
        if (rx_prev && !rx_s) state_nxt = START;
      end
      START: begin
        if (decide && maj)  state_nxt = IDLE;
        else if (end_bit)   state_nxt = DATA;
      end
      DATA: begin
        if (end_bit && (bit_cnt == 3'd7)) state_nxt = STOP;
      end
      STOP: begin
        // Decide mid-stop and return early so a back-to-back start edge is caught.
        if (decide) begin
          state_nxt = IDLE;
          good_stb  = maj;
          err_stb   = !maj;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Synchronizer, oversample timing and datapath
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_m      <= 1'b1;
      rx_s      <= 1'b1;
      rx_prev   <= 1'b1;
      div       <= '0;
      tick_cnt  <= 4'd0;
      bit_cnt   <= 3'd0;
      shift     <= 8'h00;
      s7        <= 1'b1;
      s8        <= 1'b1;
      data_out  <= 8'h00;
      valid     <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      rx_m    <= rx;
      rx_s    <= rx_m;
      rx_prev <= rx_s;

      // Divider parked at 0 in IDLE so bit phase starts at the detected edge.
      if (state == IDLE) begin
        div      <= '0;
        tick_cnt <= 4'd0;
      end else begin
        div <= os_tick ? '0 : div + DIV_W'(1);
        if (os_tick) tick_cnt <= tick_cnt + 4'd1;
      end

      if (state == START)               bit_cnt <= 3'd0;
      else if (state == DATA && end_bit) bit_cnt <= bit_cnt + 3'd1;

      if (samp && tick_cnt == 4'd7) s7 <= rx_s;
      if (samp && tick_cnt == 4'd8) s8 <= rx_s;

      if (state == DATA && decide) shift[bit_cnt] <= maj;

      if (good_stb) data_out <= shift;
      valid     <= good_stb;
      frame_err <= err_stb;
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
`timescale 1ns/1ps
module tb_uart_rx;

  // Scaled line rate keeps frames short: OS_DIV = 4, 64 clk per bit.
  localparam int CLK_FREQ = 50_000_000;
  localparam int BAUD     = 781_250;
  localparam int BIT_NS   = 1_000_000_000 / BAUD;   // 1280 ns
  localparam int BIT_CLK  = BIT_NS / 20;            // 64 clk

  logic       clk;
  logic       rst;
  logic       rx;
  logic [7:0] data_out;
  logic       valid;
  logic       frame_err;
  logic       busy;

  uart_rx #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD)) dut (
    .clk       (clk),
    .rst       (rst),
    .rx        (rx),
    .data_out  (data_out),
    .valid     (valid),
    .frame_err (frame_err),
    .busy      (busy)
  );

  initial begin
    clk = 1'b0;
    forever #10 clk = ~clk;
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct packed {
    logic       err;
    logic [7:0] dat;
  } exp_t;

  exp_t       exp_q[$];
  int         vcyc_q[$];
  logic [7:0] last_good = 8'h00;
  int         total = 0;
  int         bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic chk_range(input string name, input int act, input int lo, input int hi);
    total++;
    if (act < lo || act > hi) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d..%0d", name, act, lo, hi);
    end
  endtask

  // Reference: a frame with a high stop bit yields its byte; a low stop bit
  // yields a framing error and leaves the last good byte on data_out.
  task automatic send_frame(input logic [7:0] b, input int bit_ns, input logic stop_bit);
    exp_t e;
    e.err = !stop_bit;
    e.dat = b;
    exp_q.push_back(e);
    rx = 1'b0;
    #(bit_ns);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      #(bit_ns);
    end
    rx = stop_bit;
    #(bit_ns);
    rx = 1'b1;
  endtask

  // Monitor: pops one expectation per output strobe.
  always @(negedge clk) begin
    if (rst && (valid || frame_err)) begin
      exp_t e;
      chk("exclusive_strobes", {31'd0, valid & frame_err}, 32'd0);
      chk("busy_low_at_strobe", {31'd0, busy}, 32'd0);
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_strobe: valid=%0b frame_err=%0b data=%0h", valid, frame_err, data_out);
      end else begin
        e = exp_q.pop_front();
        chk("strobe_kind_err", {31'd0, frame_err}, {31'd0, e.err});
        if (valid) begin
          chk("data_out", {24'd0, data_out}, {24'd0, e.dat});
          last_good = e.dat;
          vcyc_q.push_back(cyc);
        end else begin
          chk("data_kept_on_err", {24'd0, data_out}, {24'd0, last_good});
        end
      end
    end
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not finish by %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int start_cyc;
    int nv;
    logic [7:0] b;
    logic       stop_b;

    rst = 1'b0;
    rx  = 1'b1;

    // Reset held with rx toggling
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      rx = ~rx;
    end
    chk("rst_data_out", {24'd0, data_out}, 32'h00);
    chk("rst_valid", {31'd0, valid}, 32'd0);
    chk("rst_frame_err", {31'd0, frame_err}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    rx = 1'b1;
    @(negedge clk);
    rst = 1'b1;
    repeat (20) @(negedge clk);
    chk("post_rst_data_out", {24'd0, data_out}, 32'h00);
    chk("post_rst_busy", {31'd0, busy}, 32'd0);

    // Single byte, busy timing and latency
    @(negedge clk);
    start_cyc = cyc;
    nv = vcyc_q.size();
    fork
      send_frame(8'hA5, BIT_NS, 1'b1);
      begin
        repeat (3) @(posedge clk);
        #1;
        chk("busy_after_start", {31'd0, busy}, 32'd1);
      end
    join
    #(BIT_NS);
    chk("single_valid_count", vcyc_q.size(), nv + 1);
    if (vcyc_q.size() > nv)
      chk_range("single_latency", vcyc_q[$] - start_cyc, 600, 630);

    // Back-to-back frames, no idle gap
    nv = vcyc_q.size();
    send_frame(8'h3C, BIT_NS, 1'b1);
    send_frame(8'hC3, BIT_NS, 1'b1);
    #(BIT_NS);
    chk("b2b_valid_count", vcyc_q.size(), nv + 2);
    if (vcyc_q.size() >= nv + 2)
      chk_range("b2b_spacing", vcyc_q[$] - vcyc_q[$-1], 10 * BIT_CLK - 4, 10 * BIT_CLK + 4);

    // Framing error, then a good frame
    send_frame(8'h55, BIT_NS, 1'b0);
    #(2 * BIT_NS);
    send_frame(8'h0F, BIT_NS, 1'b1);
    #(BIT_NS);

    // False start: low for about 0.3 bit
    @(negedge clk);
    rx = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("false_start_busy", {31'd0, busy}, 32'd1);
    #(BIT_NS * 3 / 10 - 61);
    rx = 1'b1;
    #(BIT_NS);
    chk("false_start_idle", {31'd0, busy}, 32'd0);
    send_frame(8'hFF, BIT_NS, 1'b1);
    #(BIT_NS);

    // Reset after data bit 3 of 8'h81
    b = 8'h81;
    rx = 1'b0;
    #(BIT_NS);
    for (int i = 0; i < 4; i++) begin
      rx = b[i];
      #(BIT_NS);
    end
    rst = 1'b0;
    #1;
    last_good = 8'h00;
    chk("midrst_data_out", {24'd0, data_out}, 32'h00);
    chk("midrst_valid", {31'd0, valid}, 32'd0);
    chk("midrst_frame_err", {31'd0, frame_err}, 32'd0);
    chk("midrst_busy", {31'd0, busy}, 32'd0);
    rx = 1'b1;
    #200;
    rst = 1'b1;
    #(2 * BIT_NS);
    nv = vcyc_q.size();
    send_frame(8'h81, BIT_NS * 100 / 103, 1'b1);
    #(BIT_NS);
    chk("skew_valid_count", vcyc_q.size(), nv + 1);

    // Randomized frames with occasional framing errors and random gaps
    for (int n = 0; n < 24; n++) begin
      b      = 8'($urandom);
      stop_b = ($urandom_range(0, 4) != 0);
      send_frame(b, BIT_NS, stop_b);
      if (stop_b) #($urandom_range(0, 2) * BIT_NS / 2);
      else        #(BIT_NS + $urandom_range(0, 2) * BIT_NS / 2);
    end

    #(3 * BIT_NS);
    chk("scoreboard_drained", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
